coeff_write_stage: RTL and testbench
====================================

# coeff_write_stage

Parametrised staging buffer for equalizer coefficient writes. It sits between the host-side coefficient loader and the coefficient RAM/filter bank, capturing write and write-done commands, buffering up to DEPTH commands in a FIFO and presenting them downstream with a valid/ready handshake. It detects overflow and, optionally, out-of-range addresses. This is the next generation of the single-stage input register, with configurable widths and depth and with backpressure.

## Interface
- DATA_W, 16, coefficient width (signed)
- ADDR_W, 6, coefficient address width
- DEPTH, 4, FIFO entries; power of two, ≥2
- NUM_COEFFS, 40, valid address count (8 bands × 5 biquad coefficients); addresses ≥ NUM_COEFFS are out of range
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clk_enable  in  1  global advance; when low, no state changes
- i_write_enable  in  1  write command this cycle
- i_write_done  in  1  end-of-load marker this cycle
- i_write_address  in  ADDR_W  write address
- i_coeffs_in  in  DATA_W  signed coefficient
- i_clear_err  in  1  clears sticky error flags
- i_ready  in  1  downstream accepts the presented entry
- o_ready  out  1  FIFO not full (count < DEPTH)
- o_write_enable  out  1  presented entry carries a write
- o_write_done  out  1  presented entry carries done
- o_write_address  out  ADDR_W  presented address
- o_coeffs_in  out  DATA_W  presented coefficient, signed
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register
- o_overflow  out  1  sticky: a command was dropped while full
- o_addr_error  out  1  sticky: an out-of-range write was seen

## Operation
- Entry = {we, done, addr, data}. A command is any cycle with clk_enable=1 and (i_write_enable or i_write_done).
- Push: the command is written at the tail if count < DEPTH, or if count = DEPTH and a pop happens in the same cycle. Otherwise it is dropped and o_overflow is set.
- When write and done arrive together, they form one entry with both flags set. Downstream semantics: done applies after this write.
- Output register: holds the head entry. It is "valid" when o_write_enable or o_write_done is high.
- Output register loads from the FIFO head (pop) when clk_enable=1, count > 0, and the register is either invalid or being consumed (valid and i_ready=1).
- When it is consumed with nothing to load, o_write_enable and o_write_done clear to 0. Address and data hold their last value.
- Valid entries are held stable until consumed. i_ready is ignored while invalid.
- Pointers are log2(DEPTH) bits and wrap naturally. count tracks push/pop, and a simultaneous push and pop leaves it unchanged.
- i_clear_err (with clk_enable=1) clears both sticky flags. A set event in the same cycle wins over the clear.
- clk_enable=0: the FIFO, output register, count and flags all hold. Commands and i_ready are ignored.

## Timing
- Reset (rst=1 at an edge): all outputs 0 except o_ready=1. Pointers, count and flags are 0.
- Reset mid-operation discards all buffered entries, including the output register. It dominates clk_enable.
- Latency, empty pipeline: a command accepted at edge k is pushed at edge k, moves to the output register at edge k+1, and is visible after that edge. That is 2 cycles from input to output.
- Throughput: 1 entry/cycle sustained when i_ready=1 and clk_enable=1.
- o_ready is registered-state derived (count < DEPTH). It is not combinationally dependent on i_ready.
- Ordering is strictly FIFO. No entry is reordered or duplicated.

## Configuration
- COEFF_ADDR_CHECK_EN defined: a command with i_write_enable=1 and i_write_address ≥ NUM_COEFFS sets o_addr_error and has its write flag stripped.
  - If i_write_done is also set, the entry is pushed as done-only.
  - Otherwise nothing is pushed, and the command does not count toward overflow.
- COEFF_ADDR_CHECK_EN undefined: all addresses pass unmodified, and o_addr_error is constant 0.

## Test plan
- Reset/latency: after reset, write addr=3, data=-1234 at edge k with i_ready=1. Outputs show we=1, addr=3, data=-1234 after edge k+1, and we=0 after edge k+2.
- Backpressure/full: with i_ready=0, issue 6 writes (addr 0..5). The FIFO holds 4 and the output register 1, so o_ready goes to 0 and the 6th write is dropped with o_overflow=1. Raising i_ready drains addr 0..4 in order, and o_count returns to 0.
- Push with pop at full: count=4, i_ready=1, new write addr=9. The write is accepted, o_overflow stays 0, and count stays 4.
- Combined done: write addr=39 together with done. A single entry is output with we=1 and done=1. i_clear_err then leaves flags at 0.
- clk_enable gating: clk_enable=0 for 5 cycles while a valid entry is presented, with i_ready=1 and a write toggling on the input. Outputs and o_count are unchanged, and nothing is pushed.
- Address check (macro on): write addr=40 gives o_addr_error=1 and no entry. Write addr=45 with done gives a done-only entry. With the macro off, addr=40 passes and o_addr_error=0.

Source files
------------

// File: rtl/coeff_write_stage.sv
`default_nettype none
// ============================================================================
//  Module   : coeff_write_stage
//  Purpose  : Staging FIFO for equalizer coefficient write / write-done
//             commands. Commands from the host-side loader are queued in a
//             DEPTH-entry FIFO and presented one at a time to the
//             coefficient RAM / filter bank via an output register with a
//             valid/ready handshake. Sticky flags report dropped commands
//             (overflow) and, optionally, out-of-range addresses.
//
//  Optional feature macro: COEFF_ADDR_CHECK_EN
//    defined   : writes to address >= NUM_COEFFS set o_addr_error and lose
//                their write flag (a done flag still gets queued).
//    undefined : every address passes unchanged and o_addr_error is 0.
//
//  Ports
//    clk, rst          clock, synchronous active-high reset
//    clk_enable        global advance; low freezes all state
//    i_write_enable    write command
//    i_write_done      end-of-load marker
//    i_write_address   write address        [ADDR_W]
//    i_coeffs_in       signed coefficient   [DATA_W]
//    i_clear_err       clears sticky flags
//    i_ready           downstream accepts the presented entry
//    o_ready           FIFO not full
//    o_write_enable    presented entry carries a write
//    o_write_done      presented entry carries done
//    o_write_address   presented address
//    o_coeffs_in       presented coefficient (signed)
//    o_count           FIFO occupancy, output register excluded
//    o_overflow        sticky: command dropped while full
//    o_addr_error      sticky: out-of-range write seen
//
//  Revision : 1.0  initial release
// ============================================================================
module coeff_write_stage #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 4,
    parameter int NUM_COEFFS = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_enable,
    input  logic                       i_write_enable,
    input  logic                       i_write_done,
    input  logic [ADDR_W-1:0]          i_write_address,
    input  logic signed [DATA_W-1:0]   i_coeffs_in,
    input  logic                       i_clear_err,
    input  logic                       i_ready,
    output logic                       o_ready,
    output logic                       o_write_enable,
    output logic                       o_write_done,
    output logic [ADDR_W-1:0]          o_write_address,
    output logic signed [DATA_W-1:0]   o_coeffs_in,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_addr_error
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH+1);
    localparam int c_ENTRY_W = 2 + ADDR_W + DATA_W;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]    c_NUM_ADDR  = (ADDR_W+1)'(NUM_COEFFS);

    // Storage and state
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_out_we;
    logic                 r_out_done;
    logic [ADDR_W-1:0]    r_out_addr;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_overflow;
    logic                 r_addr_error;

    // Command qualification
    logic w_addr_oob;
    logic w_addr_bad;
    logic w_we_eff;
    logic w_push_req;
    logic w_out_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_consume;
    logic [c_ENTRY_W-1:0] w_head;

    // Extra MSB keeps the compare safe when NUM_COEFFS == 2**ADDR_W.
    assign w_addr_oob = ({1'b0, i_write_address} >= c_NUM_ADDR);

`ifdef COEFF_ADDR_CHECK_EN
    assign w_addr_bad = clk_enable & i_write_enable & w_addr_oob;
`else
    logic w_unused_addr_oob;
    assign w_unused_addr_oob = w_addr_oob;
    assign w_addr_bad        = 1'b0;
`endif

    // A bad write keeps only its done flag; a bare bad write pushes nothing
    // and therefore can never count as an overflow.
    assign w_we_eff    = i_write_enable & ~w_addr_bad;
    assign w_push_req  = clk_enable & (w_we_eff | i_write_done);

    assign w_out_valid = r_out_we | r_out_done;
    assign w_consume   = clk_enable & w_out_valid & i_ready;
    assign w_pop       = clk_enable & (r_count != '0) & (~w_out_valid | i_ready);

    // A full FIFO still accepts when the head leaves in the same cycle:
    // the slot being read is the one being written, and the read sees the
    // old contents because both are non-blocking.
    assign w_push      = w_push_req & ((r_count < c_DEPTH_CNT) | w_pop);
    assign w_drop      = w_push_req & ~w_push;

    assign w_head      = r_mem[r_rd_ptr];

    // FIFO storage (no reset needed; pointers/count define validity)
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= {w_we_eff, i_write_done, i_write_address, i_coeffs_in};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_we   <= 1'b0;
            r_out_done <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else if (w_pop) begin
            {r_out_we, r_out_done, r_out_addr, r_out_data} <= w_head;
        end else if (w_consume) begin
            // Address/data intentionally keep their last value.
            r_out_we   <= 1'b0;
            r_out_done <= 1'b0;
        end
    end

    // Sticky error flags: a set event in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_addr_error <= 1'b0;
        end else if (clk_enable) begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_err) begin
                r_overflow <= 1'b0;
            end
            if (w_addr_bad) begin
                r_addr_error <= 1'b1;
            end else if (i_clear_err) begin
                r_addr_error <= 1'b0;
            end
        end
    end

    assign o_ready         = (r_count < c_DEPTH_CNT);
    assign o_write_enable  = r_out_we;
    assign o_write_done    = r_out_done;
    assign o_write_address = r_out_addr;
    assign o_coeffs_in     = r_out_data;
    assign o_count         = r_count;
    assign o_overflow      = r_overflow;
    assign o_addr_error    = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_coeff_write_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coeff_write_stage
//  Purpose  : Self-checking bench for coeff_write_stage. Directed steps for
//             the documented scenarios followed by randomized traffic, all
//             checked every cycle against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coeff_write_stage;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 6;
    localparam int DEPTH      = 4;
    localparam int NUM_COEFFS = 40;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clk_enable = 1'b0;
    logic                 i_write_enable = 1'b0;
    logic                 i_write_done = 1'b0;
    logic [ADDR_W-1:0]    i_write_address = '0;
    logic signed [DATA_W-1:0] i_coeffs_in = '0;
    logic                 i_clear_err = 1'b0;
    logic                 i_ready = 1'b0;
    logic                 o_ready;
    logic                 o_write_enable;
    logic                 o_write_done;
    logic [ADDR_W-1:0]    o_write_address;
    logic signed [DATA_W-1:0] o_coeffs_in;
    logic [2:0]           o_count;
    logic                 o_overflow;
    logic                 o_addr_error;

    coeff_write_stage #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .NUM_COEFFS (NUM_COEFFS)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .clk_enable      (clk_enable),
        .i_write_enable  (i_write_enable),
        .i_write_done    (i_write_done),
        .i_write_address (i_write_address),
        .i_coeffs_in     (i_coeffs_in),
        .i_clear_err     (i_clear_err),
        .i_ready         (i_ready),
        .o_ready         (o_ready),
        .o_write_enable  (o_write_enable),
        .o_write_done    (o_write_done),
        .o_write_address (o_write_address),
        .o_coeffs_in     (o_coeffs_in),
        .o_count         (o_count),
        .o_overflow      (o_overflow),
        .o_addr_error    (o_addr_error)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of pending commands plus the entry currently
    // shown downstream.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        we;
        logic        dn;
        logic [5:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t m_q[$];
    ent_t m_out;
    logic m_ovf;
    logic m_aerr;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef COEFF_ADDR_CHECK_EN
    localparam bit c_CHECK = 1'b1;
`else
    localparam bit c_CHECK = 1'b0;
`endif

    task automatic model_update(input logic r, input logic ce, input logic we,
                                input logic dn, input logic [5:0] a,
                                input logic [15:0] d, input logic rdy,
                                input logic clr);
        bit   shown;
        bit   take;
        bit   bad;
        bit   want;
        bit   dropped;
        ent_t e;
        if (r) begin
            m_q.delete();
            m_out  = '0;
            m_ovf  = 1'b0;
            m_aerr = 1'b0;
            return;
        end
        if (!ce) return;
        shown   = m_out.we | m_out.dn;
        take    = (m_q.size() > 0) && (!shown || rdy);
        bad     = c_CHECK && we && (int'(a) >= NUM_COEFFS);
        want    = (we && !bad) || dn;
        dropped = 1'b0;
        if (take) begin
            m_out = m_q.pop_front();
        end else if (shown && rdy) begin
            m_out.we = 1'b0;
            m_out.dn = 1'b0;
        end
        if (want) begin
            // Room exists if a slot freed this cycle (pop already applied).
            if (m_q.size() < DEPTH) begin
                e.we = we && !bad;
                e.dn = dn;
                e.a  = a;
                e.d  = d;
                m_q.push_back(e);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (bad) m_aerr = 1'b1;
        else if (clr) m_aerr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_ready",         32'(o_ready),         32'(m_q.size() < DEPTH));
        chk("o_count",         32'(o_count),         32'(m_q.size()));
        chk("o_write_enable",  32'(o_write_enable),  32'(m_out.we));
        chk("o_write_done",    32'(o_write_done),    32'(m_out.dn));
        chk("o_write_address", 32'(o_write_address), 32'(m_out.a));
        chk("o_coeffs_in",     {16'h0, o_coeffs_in}, {16'h0, m_out.d});
        chk("o_overflow",      32'(o_overflow),      32'(m_ovf));
        chk("o_addr_error",    32'(o_addr_error),    32'(m_aerr));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after
    // the rising edge.
    task automatic step(input logic r, input logic ce, input logic we,
                        input logic dn, input logic [5:0] a,
                        input logic [15:0] d, input logic rdy,
                        input logic clr);
        rst             = r;
        clk_enable      = ce;
        i_write_enable  = we;
        i_write_done    = dn;
        i_write_address = a;
        i_coeffs_in     = d;
        i_ready         = rdy;
        i_clear_err     = clr;
        model_update(r, ce, we, dn, a, d, rdy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd0, rdy, 1'b0);
    endtask

    initial begin
        logic [15:0] neg1234;
        logic [5:0]  ra;
        neg1234 = 16'hFB2E;   // -1234
        m_out  = '0;
        m_ovf  = 1'b0;
        m_aerr = 1'b0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 6'd7, 16'd7, 1'b1, 1'b0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_count", 32'(o_count), 32'd0);

        // Latency: command at edge k, visible after k+1, cleared after k+2
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd3, neg1234, 1'b1, 1'b0);
        chk("lat_k_we", 32'(o_write_enable), 32'd0);
        idle(1'b1);
        chk("lat_k1_we",   32'(o_write_enable), 32'd1);
        chk("lat_k1_addr", 32'(o_write_address), 32'd3);
        chk("lat_k1_data", {16'h0, o_coeffs_in}, {16'h0, neg1234});
        idle(1'b1);
        chk("lat_k2_we", 32'(o_write_enable), 32'd0);

        // Backpressure: six writes with downstream stalled
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 6'(i), 16'(100 + i), 1'b0, 1'b0);
        chk("bp_ready",    32'(o_ready),    32'd0);
        chk("bp_count",    32'(o_count),    32'd4);
        chk("bp_overflow", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("bp_drained", 32'(o_count), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b1);
        chk("bp_cleared", 32'(o_overflow), 32'd0);

        // Push with pop while full
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 6'(10 + i), 16'(200 + i), 1'b0, 1'b0);
        chk("full_count", 32'(o_count), 32'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd9, 16'd900, 1'b1, 1'b0);
        chk("pp_count",    32'(o_count),    32'd4);
        chk("pp_overflow", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 7; i++) idle(1'b1);

        // Combined write + done at the last valid address
        step(1'b0, 1'b1, 1'b1, 1'b1, 6'd39, 16'h1234, 1'b0, 1'b0);
        idle(1'b0);
        chk("comb_we",   32'(o_write_enable), 32'd1);
        chk("comb_done", 32'(o_write_done),   32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b1);
        chk("comb_flags", {30'd0, o_overflow, o_addr_error}, 32'd0);
        idle(1'b1);

        // clk_enable gating while an entry is presented
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd20, 16'd20, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd21, 16'd21, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'(i % 2 == 0), 1'b0, 6'd22, 16'd22, 1'b1, 1'b1);
        chk("gate_addr",  32'(o_write_address), 32'd20);
        chk("gate_count", 32'(o_count),         32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Address range check
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd40, 16'd40, 1'b1, 1'b0);
        chk("oob_count", 32'(o_count),      32'(!c_CHECK));
        chk("oob_err",   32'(o_addr_error), 32'(c_CHECK));
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 6'd45, 16'd45, 1'b0, 1'b0);
        idle(1'b0);
        chk("oob_done_we", 32'(o_write_enable), 32'(!c_CHECK));
        chk("oob_done_dn", 32'(o_write_done),   32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b1);
        idle(1'b1);

        // Randomized traffic including occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            ra = 6'($urandom_range(0, 63));
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 5) == 0),
                 ra,
                 16'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
